// File: rtl/data_memory_bank_if.sv
// Request/response bundle between the load/store stage and data_memory_bank.
// The master issues valid/ready requests; the slave returns a one-cycle response pulse.
interface data_memory_bank_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    localparam int BYTES = DATA_WIDTH / 8;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [BYTES-1:0]      req_be;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_be, req_wdata,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_be, req_wdata,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/data_memory_bank.sv
// Word-organised data memory with byte-enable stores, registered loads and a
// post-reset zeroing sweep; one request per cycle, response one cycle later.
module data_memory_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    data_memory_bank_if.slave   bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFS   = $clog2(BYTES);
    localparam int IDX   = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [IDX-1:0]        cnt_q, cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_data_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Address decode
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [IDX-1:0]        req_idx;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  req_err;

    assign word_addr    = bus.req_addr >> OFS;
    assign req_idx      = word_addr[IDX-1:0];
    assign out_of_range = ({1'b0, word_addr} >= DEPTH_EXT);
    assign req_err      = misaligned | out_of_range;

    generate
        if (OFS == 0) begin : g_no_ofs
            assign misaligned = 1'b0;
        end else begin : g_ofs
            assign misaligned = |bus.req_addr[OFS-1:0];
        end
    endgenerate

    // Array write/read port controls
    logic                  wr_en;
    logic [IDX-1:0]        wr_idx;
    logic [BYTES-1:0]      wr_be;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        wr_en       = 1'b0;
        wr_idx      = req_idx;
        wr_be       = '0;
        wr_data     = bus.req_wdata;
        rd_en       = 1'b0;

        case (state_q)
            ST_INIT: begin
                wr_en   = 1'b1;
                wr_idx  = cnt_q;
                wr_be   = '1;
                wr_data = '0;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == IDX'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_IDLE: begin
                if (bus.req_valid) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = req_err;
                    if (!req_err) begin
                        if (bus.req_write) begin
                            wr_en = 1'b1;
                            wr_be = bus.req_be;
                        end else begin
                            rd_en = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Array kept free of reset so it maps onto block RAM with byte write enables
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            for (int k = 0; k < BYTES; k++) begin
                if (wr_be[k]) begin
                    mem[wr_idx][k*8 +: 8] <= wr_data[k*8 +: 8];
                end
            end
        end
    end

    // Store and error responses carry zero data
    always_ff @(posedge clk) begin
        if (rst || !rd_en) begin
            rsp_data_q <= '0;
        end else begin
            rsp_data_q <= mem[req_idx];
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_data_memory_bank.sv
// Scoreboard bench for data_memory_bank: directed scenarios plus randomized traffic
// checked against a byte-addressed reference memory.
module tb_data_memory_bank;
    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 32;
    localparam int BYTES = DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_memory_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    data_memory_bank #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            due;
        logic [AW-1:0] addr;
        logic          wr;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] ref_mem [DEPTH*BYTES];
    int         cyc   = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void ref_clear();
        for (int i = 0; i < DEPTH * BYTES; i++) ref_mem[i] = 8'h00;
    endfunction

    function automatic logic addr_err(input logic [AW-1:0] a);
        return ((a % BYTES) != 0) || ((a / BYTES) >= DEPTH);
    endfunction

    // Monitor: every response pulse is matched against the oldest expectation
    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rsp: rsp_valid=1 with nothing outstanding, required 0 (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_cycle", 64'(cyc), 64'(mon_e.due));
                check("rsp_data", 64'(bus.rsp_data), 64'(mon_e.data));
                check("rsp_err", 64'(bus.rsp_err), 64'(mon_e.err));
                $display("rsp cyc=%0d %s addr=%h data=%h err=%b", cyc,
                         mon_e.wr ? "ST" : "LD", mon_e.addr, bus.rsp_data, bus.rsp_err);
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_rsp: rsp_valid=%b required 1 for addr %h (cycle %0d)",
                     bus.rsp_valid, mon_e.addr, cyc);
        end
    end

    // Called just after a falling edge; the request is accepted on the next rising edge
    task automatic issue(input logic wr, input logic [AW-1:0] a,
                         input logic [BYTES-1:0] be, input logic [DW-1:0] wd);
        exp_t e;
        check("req_ready", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_be    = be;
        bus.req_wdata = wd;
        e.err  = addr_err(a);
        e.data = '0;
        e.due  = cyc + 1;
        e.addr = a;
        e.wr   = wr;
        if (!e.err) begin
            for (int k = 0; k < BYTES; k++) begin
                if (wr) begin
                    if (be[k]) ref_mem[a + k] = wd[k*8 +: 8];
                end else begin
                    e.data[k*8 +: 8] = ref_mem[a + k];
                end
            end
        end
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Holds rst for n rising edges; with_req also presents a load that must be ignored
    task automatic do_reset(input int n, input logic with_req);
        rst           = 1'b1;
        bus.req_valid = with_req;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h0000_0020;
        @(posedge clk);
        #1;
        sb.delete();
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        check("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        bus.req_valid = 1'b0;
        repeat (n - 1) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ref_clear();
    endtask

    // Sweep window: ready stays low and random requests are ignored
    task automatic run_init(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            check("init_ready", 64'(bus.req_ready), 64'd0);
            bus.req_valid = 1'($urandom);
            bus.req_write = 1'($urandom);
            bus.req_addr  = 32'($urandom_range(0, DEPTH - 1) * BYTES);
            bus.req_be    = '1;
            bus.req_wdata = $urandom;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        int            r;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_be    = '0;
        bus.req_wdata = '0;
        ref_clear();

        // 1: reset, full sweep window, then a load from the last word
        do_reset(2, 1'b0);
        run_init(DEPTH);
        check("ready_after_init", 64'(bus.req_ready), 64'd1);
        issue(1'b0, 32'h0000_007C, '0, '0);
        idle(2);

        // 2, 3: full store, load-after-store, partial store
        issue(1'b1, 32'h0000_0010, 4'hF, 32'hDEADBEEF);
        issue(1'b0, 32'h0000_0010, '0, '0);
        issue(1'b1, 32'h0000_0010, 4'h5, 32'h11223344);
        issue(1'b0, 32'h0000_0010, '0, '0);
        issue(1'b1, 32'h0000_0010, 4'h0, 32'hFFFF_FFFF);
        issue(1'b0, 32'h0000_0010, '0, '0);
        idle(1);

        // 4: misaligned store, out-of-range load, word untouched
        issue(1'b1, 32'h0000_0012, 4'hF, 32'hCAFEF00D);
        issue(1'b0, 32'h0000_0080, '0, '0);
        issue(1'b0, 32'h0000_0010, '0, '0);
        idle(1);

        // 5: back-to-back loads
        issue(1'b1, 32'h0000_0004, 4'hF, 32'hA5A5_0004);
        issue(1'b1, 32'h0000_0008, 4'hF, 32'h5A5A_0008);
        issue(1'b0, 32'h0000_0000, '0, '0);
        issue(1'b0, 32'h0000_0004, '0, '0);
        issue(1'b0, 32'h0000_0008, '0, '0);
        idle(2);

        // 6a: reset part way through the sweep restarts it
        do_reset(1, 1'b0);
        run_init(10);
        do_reset(1, 1'b0);
        run_init(DEPTH);
        check("ready_after_reinit", 64'(bus.req_ready), 64'd1);

        // 6b: reset right after a load accept, and reset overriding a request
        issue(1'b1, 32'h0000_0020, 4'hF, 32'h1234_5678);
        issue(1'b0, 32'h0000_0020, '0, '0);
        do_reset(2, 1'b1);
        run_init(DEPTH);
        issue(1'b0, 32'h0000_0020, '0, '0);
        issue(1'b0, 32'h0000_0004, '0, '0);
        idle(1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            r = $urandom_range(0, 9);
            if (r < 7)       a = 32'($urandom_range(0, DEPTH - 1) * BYTES);
            else if (r == 7) a = 32'($urandom_range(0, DEPTH * BYTES - 1) | 1);
            else if (r == 8) a = 32'(DEPTH * BYTES + $urandom_range(0, 7) * BYTES);
            else             a = $urandom;
            issue(1'($urandom), a, 4'($urandom_range(0, 15)), $urandom);
        end
        idle(3);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/data_memory_bank.md
Name: data_memory_bank

Overview:
- Parametrised successor to the single-cycle data memory used by the CPU datapath.
- Adds a reset-driven clear sweep, per-byte write enables, and a registered read with fixed one-cycle latency.
- Uses a valid/ready request port and a response pulse carrying an error flag for misaligned or out-of-range byte addresses.
- Sits between the CPU load/store stage and the memory array; one request per cycle at full throughput.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- DEPTH, 32, number of words; must be at least 2.
- ADDR_WIDTH, 32, byte-address width.
- Derived: BYTES = DATA_WIDTH/8; OFS = log2(BYTES); IDX = log2(DEPTH), rounded up.

Ports:
- clk  in  1  clock; every state change happens on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  a request is present.
- req_ready  out  1  the block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  byte address.
- req_be  in  BYTES  byte enables for stores; bit k selects data bits [8k+7:8k].
- req_wdata  in  DATA_WIDTH  store data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_data  out  DATA_WIDTH  load data.
- rsp_err  out  1  the request was misaligned or out of range.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state = INIT, sweep counter = 0, req_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_err = 0.
- INIT state:
  - Each cycle writes all-zero to word[counter], then increments the counter.
  - After writing word DEPTH-1, moves to IDLE on the next edge. INIT lasts exactly DEPTH cycles after rst falls.
  - req_ready = 0 throughout; any req_valid is ignored.
- IDLE state: req_ready = 1 (combinational from state). A request is accepted on an edge where req_valid & req_ready.
- Address decode:
  - idx = req_addr[OFS+IDX-1:OFS].
  - misaligned = (req_addr[OFS-1:0] != 0).
  - out-of-range = (req_addr >> OFS) >= DEPTH.
  - err = misaligned | out-of-range.
- Accepted store, err = 0:
  - On the accept edge, byte k of word[idx] takes req_wdata byte k when req_be[k] = 1.
  - Bytes with req_be[k] = 0 are unchanged. req_be = 0 is legal: no change, no error.
- Accepted load, err = 0: rsp_data is registered from word[idx] on the accept edge.
- Response timing:
  - rsp_valid = 1 for exactly the cycle after each accept.
  - rsp_err is registered with the response.
  - Store responses drive rsp_data = 0.
- Error requests: no array write; rsp_data = 0; rsp_err = 1.
- No response backpressure; rsp_valid is 0 whenever no accept occurred on the previous edge.
- Throughput: one request per cycle.
- Ordering:
  - A load accepted the cycle after a store to the same word returns the stored data.
  - Only one request can be presented per cycle, so no same-cycle read/write conflict exists.
- Reset during INIT: the sweep restarts from 0.
- Reset in IDLE:
  - Any pending response is dropped; rsp_valid = 0 on the edge after rst.
  - Array contents are re-cleared by the new sweep.
- Reset priority: rst overrides req_valid on the same edge.
- Array contents are never X after INIT completes.

Test Plan:
1. rst high 2 cycles, then low → req_ready = 0 for 32 cycles, 1 on cycle 33. A load from 0x7C then returns rsp_data = 0x00000000, rsp_err = 0.
2. Store 0x0000_0010 ← 0xDEADBEEF with be = 0xF, then load 0x10 next cycle → rsp_valid one cycle after each accept. Load returns 0xDEADBEEF.
3. Store 0x10 ← 0x11223344 with be = 0x5, then load 0x10 → 0xDE22BE44.
4. Store to 0x12 (misaligned) and load from 0x80 (out of range) → rsp_err = 1 and rsp_data = 0 for both. A following load from 0x10 returns an unchanged word.
5. Back-to-back loads on consecutive cycles to 0x0, 0x4, 0x8 → three consecutive rsp_valid pulses in request order.
6. Assert rst at INIT count 10, and separately the cycle after a load accept → sweep restarts with a full 32-cycle ready = 0 window. The pending rsp_valid is suppressed.
